// File: rtl/i2c_reg_slave_if.sv
// Register-side port bundle of the I2C register target: the target drives the
// pointer, write data and strobes; the host register file returns read data.
interface i2c_reg_slave_if;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       busy;

    modport slave  (output reg_addr, reg_wdata, reg_we, reg_re, busy, input  reg_rdata);
    modport master (input  reg_addr, reg_wdata, reg_we, reg_re, busy, output reg_rdata);
endinterface

// File: rtl/i2c_reg_slave.sv
// I2C target with an 8-bit register pointer and 8-bit data. Supports single and
// burst writes, reads via repeated START, and pointer auto-increment (wrapping).
// sda is only ever pulled low; every other time it is released to the pull-up.
module i2c_reg_slave #(
    parameter logic [6:0]  DEV_ADDR   = 7'h39,
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           scl,
    inout  wire            sda,
    i2c_reg_slave_if.slave regs
);
    localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0, ST_DEVADDR = 4'd1, ST_ACK_DEV = 4'd2, ST_REGADDR = 4'd3,
        ST_ACK_REG = 4'd4, ST_WDATA   = 4'd5, ST_ACK_WR  = 4'd6, ST_RDATA   = 4'd7,
        ST_ACK_MST = 4'd8, ST_IGNORE  = 4'd9
    } state_t;

    // Line index 0 is scl, index 1 is sda.
    logic [1:0]    sync1_r, sync2_r, filt_r, filt_q_r;
    logic [CW-1:0] flt_cnt_r [2];

    state_t      state_r, state_n;
    logic [3:0]  bit_cnt_r, bit_cnt_n;
    logic [7:0]  shift_r, shift_n;
    logic        rw_r, rw_n;
    logic [7:0]  addr_r, addr_n;
    logic [7:0]  wdata_r, wdata_n;
    logic        we_r, we_n, re_r, re_n, busy_r, busy_n, drive_r, drive_n;

    logic        scl_rise_s, scl_fall_s, start_s, stop_s, sda_in_s;
    logic        ack_begin_s, ack_done_s, addr_match_s;
    logic [7:0]  byte_s;

    // Synchronize both bus lines and accept a new level only after it has held
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r  <= 2'b11;
            sync2_r  <= 2'b11;
            filt_r   <= 2'b11;
            filt_q_r <= 2'b11;
            for (int i = 0; i < 2; i++) flt_cnt_r[i] <= {CW{1'b0}};
        end else begin
            sync1_r  <= {sda, scl};
            sync2_r  <= sync1_r;
            filt_q_r <= filt_r;
            for (int i = 0; i < 2; i++) begin
                if (sync2_r[i] == filt_r[i]) begin
                    flt_cnt_r[i] <= {CW{1'b0}};
                end else if (flt_cnt_r[i] == CW'(FILTER_LEN - 1)) begin
                    filt_r[i]    <= sync2_r[i];
                    flt_cnt_r[i] <= {CW{1'b0}};
                end else begin
                    flt_cnt_r[i] <= flt_cnt_r[i] + {{(CW-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    assign sda_in_s     = filt_r[1];
    assign scl_rise_s   =  filt_r[0] & ~filt_q_r[0];
    assign scl_fall_s   = ~filt_r[0] &  filt_q_r[0];
    assign start_s      =  filt_r[0] &  filt_q_r[0] &  filt_q_r[1] & ~filt_r[1];
    assign stop_s       =  filt_r[0] &  filt_q_r[0] & ~filt_q_r[1] &  filt_r[1];
    assign byte_s       = {shift_r[6:0], sda_in_s};
    assign addr_match_s = (byte_s[7:1] == DEV_ADDR) && (byte_s[7:1] != 7'h00);
    // The first scl fall of an ACK slot pulls sda low, the second one ends it.
    assign ack_begin_s  = scl_fall_s & ~drive_r;
    assign ack_done_s   = scl_fall_s &  drive_r;

    // Protocol decisions: START/STOP win in any state, otherwise per-state bus events
    always_comb begin
        state_n   = state_r;
        bit_cnt_n = bit_cnt_r;
        rw_n      = rw_r;
        addr_n    = addr_r;
        wdata_n   = wdata_r;
        we_n      = 1'b0;
        re_n      = 1'b0;
        busy_n    = busy_r;
        drive_n   = drive_r;
        // Read data arrives one clk after the read strobe.
        if (re_r) begin
            shift_n = regs.reg_rdata;
        end else begin
            shift_n = shift_r;
        end
        if (start_s) begin
            state_n   = ST_DEVADDR;
            bit_cnt_n = 4'd0;
            drive_n   = 1'b0;
        end else if (stop_s) begin
            state_n   = ST_IDLE;
            bit_cnt_n = 4'd0;
            drive_n   = 1'b0;
            busy_n    = 1'b0;
        end else begin
            case (state_r)
                ST_DEVADDR, ST_REGADDR, ST_WDATA: begin
                    if (scl_rise_s) begin
                        shift_n   = byte_s;
                        bit_cnt_n = bit_cnt_r + 4'd1;
                        if (bit_cnt_r == 4'd7) begin
                            bit_cnt_n = 4'd0;
                            if (state_r == ST_REGADDR) begin
                                addr_n  = byte_s;
                                state_n = ST_ACK_REG;
                            end else if (state_r == ST_WDATA) begin
                                wdata_n = byte_s;
                                we_n    = 1'b1;
                                state_n = ST_ACK_WR;
                            end else if (addr_match_s) begin
                                busy_n  = 1'b1;
                                rw_n    = byte_s[0];
                                re_n    = byte_s[0];
                                state_n = ST_ACK_DEV;
                            end else begin
                                drive_n = 1'b0;
                                state_n = ST_IGNORE;
                            end
                        end else begin
                            state_n = state_r;
                        end
                    end else begin
                        state_n = state_r;
                    end
                end
                ST_ACK_DEV, ST_ACK_REG, ST_ACK_WR: begin
                    if (ack_done_s) begin
                        bit_cnt_n = 4'd0;
                        drive_n   = 1'b0;
                        if (state_r == ST_ACK_WR) begin
                            addr_n  = addr_r + 8'd1;
                            state_n = ST_WDATA;
                        end else if (state_r == ST_ACK_REG) begin
                            state_n = ST_WDATA;
                        end else if (rw_r) begin
                            drive_n = ~shift_r[7];
                            state_n = ST_RDATA;
                        end else begin
                            state_n = ST_REGADDR;
                        end
                    end else if (ack_begin_s) begin
                        drive_n = 1'b1;
                    end else begin
                        drive_n = drive_r;
                    end
                end
                ST_RDATA: begin
                    if (scl_rise_s) begin
                        bit_cnt_n = bit_cnt_r + 4'd1;
                    end else if (scl_fall_s) begin
                        if (bit_cnt_r == 4'd8) begin
                            bit_cnt_n = 4'd0;
                            drive_n   = 1'b0;
                            state_n   = ST_ACK_MST;
                        end else begin
                            shift_n = {shift_r[6:0], 1'b0};
                            drive_n = ~shift_r[6];
                        end
                    end else begin
                        bit_cnt_n = bit_cnt_r;
                    end
                end
                ST_ACK_MST: begin
                    if (scl_rise_s) begin
                        if (!sda_in_s) begin
                            // Bit count 9 marks "master acknowledged, fetch issued".
                            addr_n    = addr_r + 8'd1;
                            re_n      = 1'b1;
                            bit_cnt_n = 4'd9;
                        end else begin
                            drive_n = 1'b0;
                            state_n = ST_IGNORE;
                        end
                    end else if (scl_fall_s && (bit_cnt_r == 4'd9)) begin
                        bit_cnt_n = 4'd0;
                        drive_n   = ~shift_r[7];
                        state_n   = ST_RDATA;
                    end else begin
                        drive_n = 1'b0;
                    end
                end
                ST_IDLE, ST_IGNORE: begin
                    drive_n = 1'b0;
                end
                default: begin
                    drive_n = 1'b0;
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    // Protocol state and registered register-side outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 4'd0;
            shift_r   <= 8'h00;
            rw_r      <= 1'b0;
            addr_r    <= 8'h00;
            wdata_r   <= 8'h00;
            we_r      <= 1'b0;
            re_r      <= 1'b0;
            busy_r    <= 1'b0;
            drive_r   <= 1'b0;
        end else begin
            state_r   <= state_n;
            bit_cnt_r <= bit_cnt_n;
            shift_r   <= shift_n;
            rw_r      <= rw_n;
            addr_r    <= addr_n;
            wdata_r   <= wdata_n;
            we_r      <= we_n;
            re_r      <= re_n;
            busy_r    <= busy_n;
            drive_r   <= drive_n;
        end
    end

    assign sda            = drive_r ? 1'b0 : 1'bz;
    assign regs.reg_addr  = addr_r;
    assign regs.reg_wdata = wdata_r;
    assign regs.reg_we    = we_r;
    assign regs.reg_re    = re_r;
    assign regs.busy      = busy_r;
endmodule

// File: tb/tb_i2c_reg_slave.sv
// Bench for i2c_reg_slave: the bench is the bus master; a host register file
// answers the register port; a transaction-level model (register array plus
// pointer arithmetic) predicts every write/read strobe and every read byte.
module tb_i2c_reg_slave;
    localparam int Q = 8;   // clk cycles per quarter SCL period

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic scl_m = 1'b1;
    logic sda_low = 1'b0;
    logic init_mem = 1'b1;
    logic chk_release = 1'b0;
    wire  sda;

    logic [7:0]  host_mem  [256];
    logic [7:0]  model_mem [256];
    logic [15:0] exp_wq [$];
    logic [7:0]  exp_rq [$];
    logic [7:0]  wbuf [$];
    logic [7:0]  rbuf [$];
    logic [7:0]  last_we_addr = 8'h00;
    logic [7:0]  last_we_data = 8'h00;
    int          ptr = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    i2c_reg_slave_if dif ();

    assign sda = sda_low ? 1'b0 : 1'bz;
    pullup (sda);
    assign dif.reg_rdata = host_mem[dif.reg_addr];

    i2c_reg_slave #(.DEV_ADDR(7'h39), .FILTER_LEN(3)) dut (
        .clk   (clk),
        .reset (reset),
        .scl   (scl_m),
        .sda   (sda),
        .regs  (dif)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_init(input int i);
        return 8'((i * 37 + 19) % 256);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Host register file: preload once, then absorb write strobes
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) host_mem[i] <= mem_init(i);
        end else if (dif.reg_we) begin
            host_mem[dif.reg_addr] <= dif.reg_wdata;
        end
    end

    // Compare process: every strobe must match the model's next expected access
    always @(negedge clk) begin
        if (reset) begin
            if (dif.reg_we) begin
                last_we_addr = dif.reg_addr;
                last_we_data = dif.reg_wdata;
                if (exp_wq.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_we: addr %02h data %02h, none expected", dif.reg_addr, dif.reg_wdata);
                end else begin
                    logic [15:0] e;
                    e = exp_wq.pop_front();
                    check("we_addr", 32'(dif.reg_addr), 32'(e[15:8]));
                    check("we_data", 32'(dif.reg_wdata), 32'(e[7:0]));
                end
            end
            if (dif.reg_re) begin
                if (exp_rq.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_re: addr %02h, none expected", dif.reg_addr);
                end else begin
                    logic [7:0] ea;
                    ea = exp_rq.pop_front();
                    check("re_addr", 32'(dif.reg_addr), 32'(ea));
                end
            end
            if (chk_release && !sda_low) check("sda_released", 32'(sda), 32'd1);
        end
    end

    task automatic wq(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic m_start();
        sda_low = 1'b0; wq(Q);
        scl_m = 1'b1;   wq(Q);
        sda_low = 1'b1; wq(Q);
        scl_m = 1'b0;   wq(Q);
    endtask

    task automatic m_stop();
        sda_low = 1'b1; wq(Q);
        scl_m = 1'b1;   wq(Q);
        sda_low = 1'b0; wq(2 * Q);
    endtask

    task automatic m_bit_w(input logic b, input logic glitch);
        sda_low = ~b;
        if (glitch) begin
            wq(2); scl_m = 1'b1; wq(1); scl_m = 1'b0; wq(Q - 3);
        end else begin
            wq(Q);
        end
        scl_m = 1'b1; wq(2 * Q);
        scl_m = 1'b0; wq(Q);
    endtask

    task automatic m_bit_r(output logic b);
        sda_low = 1'b0; wq(Q);
        scl_m = 1'b1;   wq(Q);
        b = (sda === 1'b0) ? 1'b0 : 1'b1;
        wq(Q);
        scl_m = 1'b0;   wq(Q);
    endtask

    task automatic m_write_byte(input logic [7:0] d, input int glitch_bit, output logic ack);
        for (int i = 7; i >= 0; i--) m_bit_w(d[i], i == glitch_bit);
        m_bit_r(ack);
    endtask

    task automatic do_write(input logic [7:0] addr, input int glitch_bit);
        logic ack;
        m_start();
        m_write_byte(8'h72, -1, ack); check("dev_ack_w", 32'(ack), 32'd0);
        m_write_byte(addr, -1, ack);  check("reg_ack_w", 32'(ack), 32'd0);
        ptr = int'(addr);
        for (int k = 0; k < wbuf.size(); k++) begin
            exp_wq.push_back({8'(ptr), wbuf[k]});
            m_write_byte(wbuf[k], glitch_bit, ack);
            check("data_ack", 32'(ack), 32'd0);
            model_mem[ptr] = wbuf[k];
            ptr = (ptr + 1) % 256;
        end
        check("busy_in_write", 32'(dif.busy), 32'd1);
        m_stop();
        check("busy_after_write", 32'(dif.busy), 32'd0);
        check("we_all_seen", 32'(exp_wq.size()), 32'd0);
    endtask

    task automatic do_read(input logic [7:0] addr, input int n);
        logic ack, b;
        logic [7:0] d;
        rbuf.delete();
        m_start();
        m_write_byte(8'h72, -1, ack); check("dev_ack_w", 32'(ack), 32'd0);
        m_write_byte(addr, -1, ack);  check("reg_ack_w", 32'(ack), 32'd0);
        ptr = int'(addr);
        m_start();
        exp_rq.push_back(8'(ptr));
        m_write_byte(8'h73, -1, ack); check("dev_ack_r", 32'(ack), 32'd0);
        check("busy_in_read", 32'(dif.busy), 32'd1);
        for (int k = 0; k < n; k++) begin
            for (int i = 7; i >= 0; i--) begin
                m_bit_r(b);
                d[i] = b;
            end
            check("rdata", 32'(d), 32'(model_mem[ptr]));
            rbuf.push_back(d);
            if (k < n - 1) begin
                ptr = (ptr + 1) % 256;
                exp_rq.push_back(8'(ptr));
                m_bit_w(1'b0, 1'b0);
            end else begin
                m_bit_w(1'b1, 1'b0);
            end
        end
        m_stop();
        check("busy_after_read", 32'(dif.busy), 32'd0);
        check("re_all_seen", 32'(exp_rq.size()), 32'd0);
    endtask

    task automatic do_mismatch(input logic [7:0] dev);
        logic ack;
        chk_release = 1'b1;
        m_start();
        m_write_byte(dev, -1, ack);   check("nack_dev", 32'(ack), 32'd1);
        m_write_byte(8'h41, -1, ack); check("nack_next", 32'(ack), 32'd1);
        check("busy_mismatch", 32'(dif.busy), 32'd0);
        m_stop();
        chk_release = 1'b0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic ack;
        for (int i = 0; i < 256; i++) model_mem[i] = mem_init(i);
        wq(4);
        init_mem = 1'b0;
        check("rst_addr",  32'(dif.reg_addr),  32'h00);
        check("rst_wdata", 32'(dif.reg_wdata), 32'h00);
        check("rst_we",    32'(dif.reg_we),    32'd0);
        check("rst_re",    32'(dif.reg_re),    32'd0);
        check("rst_busy",  32'(dif.busy),      32'd0);
        check("rst_sda",   32'(sda),           32'd1);
        reset = 1'b1;
        wq(4 * Q);

        // single write
        wbuf.delete(); wbuf.push_back(8'h10);
        do_write(8'h41, -1);
        check("t1_we_addr", 32'(last_we_addr), 32'h41);
        check("t1_we_data", 32'(last_we_data), 32'h10);

        // read via repeated START
        do_read(8'h00, 1);
        check("t2_byte", 32'(rbuf[0]), 32'h13);

        // burst write across the pointer wrap, burst reads
        wbuf.delete(); wbuf.push_back(8'hAA); wbuf.push_back(8'hBB); wbuf.push_back(8'hCC);
        do_write(8'hFE, -1);
        check("t3_wrap_addr", 32'(last_we_addr), 32'h00);
        check("t3_wrap_data", 32'(last_we_data), 32'hCC);
        do_read(8'h10, 4);
        check("t3_first", 32'(rbuf[0]), 32'h63);
        do_read(8'hFE, 3);
        check("t3_rd_wrap", 32'(rbuf[2]), 32'hCC);

        // address mismatch and general call
        do_mismatch(8'h50);
        do_mismatch(8'h00);

        // 1-clk scl glitch inside a data byte is ignored
        wbuf.delete(); wbuf.push_back(8'h5A);
        do_write(8'h20, 3);
        do_read(8'h20, 1);
        check("t5_glitch_byte", 32'(rbuf[0]), 32'h5A);

        // STOP after 4 data bits discards the partial byte
        m_start();
        m_write_byte(8'h72, -1, ack); check("abort_dev_ack", 32'(ack), 32'd0);
        m_write_byte(8'h21, -1, ack); check("abort_reg_ack", 32'(ack), 32'd0);
        for (int i = 0; i < 4; i++) m_bit_w(1'b0, 1'b0);
        m_stop();
        check("abort_busy", 32'(dif.busy), 32'd0);
        check("abort_addr", 32'(dif.reg_addr), 32'h21);
        check("abort_no_we", 32'(exp_wq.size()), 32'd0);

        // randomized transactions against the model
        for (int t = 0; t < 10; t++) begin
            logic [7:0] a;
            int len;
            a = 8'($urandom_range(255, 0));
            len = int'($urandom_range(4, 1));
            if ($urandom_range(1, 0) == 1) begin
                wbuf.delete();
                for (int k = 0; k < len; k++) wbuf.push_back(8'($urandom_range(255, 0)));
                do_write(a, -1);
            end else begin
                do_read(a, len);
            end
        end

        // reset while the target is pulling sda low in a read
        wbuf.delete(); wbuf.push_back(8'h00);
        do_write(8'h30, -1);
        m_start();
        m_write_byte(8'h72, -1, ack); check("r6_dev_ack", 32'(ack), 32'd0);
        m_write_byte(8'h30, -1, ack); check("r6_reg_ack", 32'(ack), 32'd0);
        m_start();
        exp_rq.push_back(8'h30);
        m_write_byte(8'h73, -1, ack); check("r6_rd_ack", 32'(ack), 32'd0);
        sda_low = 1'b0; wq(Q);
        scl_m = 1'b1;   wq(Q);
        check("r6_driving", 32'(sda), 32'd0);
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        check("r6_sda_rel", 32'(sda), 32'd1);
        check("r6_busy", 32'(dif.busy), 32'd0);
        check("r6_addr", 32'(dif.reg_addr), 32'h00);
        wq(3);
        reset = 1'b1;
        wq(2 * Q);
        check("r6_re_seen", 32'(exp_rq.size()), 32'd0);

        // recovery after reset
        wbuf.delete(); wbuf.push_back(8'h3C);
        do_write(8'h77, -1);
        do_read(8'h77, 1);
        check("recover_byte", 32'(rbuf[0]), 32'h3C);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
